// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the CPU run/boot sequencer.
//   state_e       : controller FSM state encodings (exported on the state port)
//   IMEM_ADDR_W   : instruction RAM word-address width
//   HALT_INST_DEF : EBREAK encoding that makes the CPU halt itself
package cpu_ctrl_pkg;

  localparam int          IMEM_ADDR_W   = 12;
  localparam logic [31:0] HALT_INST_DEF = 32'h0010_0073;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_RUN  = 3'd2,
    ST_STEP = 3'd3,
    ST_HALT = 3'd4
  } state_e;

endpackage

// File: rtl/cpu_run_ctrl_imem_loader.sv
// Program image loader: accepts a valid/ready word stream and drives the
// instruction RAM write port, one registered write per accepted word.
//   i_start      : (re)start a load at address 0; clears count and overflow
//   i_valid/o_ready/i_data/i_last : load stream
//   o_done       : the current handshake ends the load (last word or overflow)
//   o_we/o_waddr/o_wdata : registered RAM write port
//   o_count      : words written in the last/current load
//   o_err        : sticky overflow, cleared by i_start
module imem_loader
  import cpu_ctrl_pkg::*;
#(
  parameter int ADDR_W = IMEM_ADDR_W,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_start,
  input  logic              i_valid,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_last,
  output logic              o_ready,
  output logic              o_done,
  output logic              o_we,
  output logic [ADDR_W-1:0] o_waddr,
  output logic [DATA_W-1:0] o_wdata,
  output logic [ADDR_W:0]   o_count,
  output logic              o_err
);

  localparam logic [ADDR_W-1:0] ONE_A = 1;
  localparam logic [ADDR_W:0]   ONE_C = 1;

  logic              r_active;
  logic              r_full;    // all 2^ADDR_W words written, no last seen
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W:0]   r_count;
  logic              r_err;
  logic              r_we;
  logic [ADDR_W-1:0] r_waddr;
  logic [DATA_W-1:0] r_wdata;
  logic              w_hs;

  assign w_hs    = i_valid & r_active;
  // A restart in the same cycle discards the word and keeps loading.
  assign o_done  = w_hs & (r_full | i_last) & ~i_start;
  assign o_ready = r_active;
  assign o_we    = r_we;
  assign o_waddr = r_waddr;
  assign o_wdata = r_wdata;
  assign o_count = r_count;
  assign o_err   = r_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_active <= 1'b0;
      r_full   <= 1'b0;
      r_addr   <= '0;
      r_count  <= '0;
      r_err    <= 1'b0;
      r_we     <= 1'b0;
      r_waddr  <= '0;
      r_wdata  <= '0;
    end else begin
      r_we <= 1'b0;
      if (i_start) begin
        r_active <= 1'b1;
        r_full   <= 1'b0;
        r_addr   <= '0;
        r_count  <= '0;
        r_err    <= 1'b0;
      end else if (w_hs) begin
        if (r_full) begin
          // Word beyond RAM capacity: dropped, flagged, load ends.
          r_err    <= 1'b1;
          r_active <= 1'b0;
        end else begin
          r_we    <= 1'b1;
          r_waddr <= r_addr;
          r_wdata <= i_data;
          r_addr  <= r_addr + ONE_A;
          r_count <= r_count + ONE_C;
          if (i_last)       r_active <= 1'b0;
          else if (&r_addr) r_full   <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run/boot sequencer for the single-issue CPU. Loads a program image into
// instruction RAM while holding the CPU in reset, then gates fetch for
// run / halt (request or EBREAK) / single-step.
//   load_*      : program image stream and load start
//   run/halt/step_req : execution control pulses
//   fetch_inst  : instruction entering execute, watched for EBREAK
//   imem_*      : instruction RAM write port
//   cpu_rst_n, pc_en : CPU reset and fetch enable
//   halted, state, load_count, err_overflow : status
module cpu_run_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter int                ADDR_W    = IMEM_ADDR_W,
  parameter int                DATA_W    = 32,
  parameter logic [DATA_W-1:0] HALT_INST = HALT_INST_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_start,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_last,
  output logic              load_ready,
  input  logic              run_req,
  input  logic              halt_req,
  input  logic              step_req,
  input  logic [DATA_W-1:0] fetch_inst,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_waddr,
  output logic [DATA_W-1:0] imem_wdata,
  output logic              cpu_rst_n,
  output logic              pc_en,
  output logic              halted,
  output logic [2:0]        state,
  output logic [ADDR_W:0]   load_count,
  output logic              err_overflow
);

  state_e r_state;
  state_e w_nxt;
  logic   r_cpu_rst_n;
  logic   r_pc_en;
  logic   r_halted;
  logic   w_load_done;

  imem_loader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_loader (
    .clk     (clk),
    .rst     (rst),
    .i_start (load_start),
    .i_valid (load_valid),
    .i_data  (load_data),
    .i_last  (load_last),
    .o_ready (load_ready),
    .o_done  (w_load_done),
    .o_we    (imem_we),
    .o_waddr (imem_waddr),
    .o_wdata (imem_wdata),
    .o_count (load_count),
    .o_err   (err_overflow)
  );

  // load_start is accepted from every state and always wins.
  always_comb begin
    w_nxt = r_state;
    if (load_start) begin
      w_nxt = ST_LOAD;
    end else begin
      unique case (r_state)
        ST_IDLE: if (run_req) w_nxt = ST_RUN;
        ST_LOAD: if (w_load_done) w_nxt = ST_IDLE;
        ST_RUN:  if (halt_req || (r_pc_en && fetch_inst == HALT_INST)) w_nxt = ST_HALT;
        ST_HALT: begin
          if (step_req)     w_nxt = ST_STEP;
          else if (run_req) w_nxt = ST_RUN;
        end
        ST_STEP: w_nxt = ST_HALT;
        default: w_nxt = ST_IDLE;
      endcase
    end
  end

  // Outputs are registered from the next state so they change with it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_cpu_rst_n <= 1'b0;
      r_pc_en     <= 1'b0;
      r_halted    <= 1'b0;
    end else begin
      r_state     <= w_nxt;
      r_cpu_rst_n <= (w_nxt == ST_RUN) || (w_nxt == ST_STEP) || (w_nxt == ST_HALT);
      r_pc_en     <= (w_nxt == ST_RUN) || (w_nxt == ST_STEP);
      r_halted    <= (w_nxt == ST_HALT);
    end
  end

  assign state     = r_state;
  assign cpu_rst_n = r_cpu_rst_n;
  assign pc_en     = r_pc_en;
  assign halted    = r_halted;

endmodule

// File: doc/cpu_run_ctrl.md
Name: cpu_run_ctrl

Overview:
Run/boot sequencer for the single-issue fetch/execute CPU. It loads a program image into instruction RAM over a valid/ready stream, holds the CPU in reset during loading, and then releases it. It gates the fetch stage with pc_en to support run, halt (external request or EBREAK) and single-step. It sits between the host/debug interface and the CPU's inst_ram write port, rst_n input and fetch-enable input.

Parameters:
ADDR_W, 12, instruction RAM word-address width (4096 words)
DATA_W, 32, instruction word width
HALT_INST, 32'h00100073, instruction encoding that self-halts the CPU (EBREAK)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
load_start  in  1  pulse: begin program load at address 0
load_valid  in  1  load word valid
load_data  in  DATA_W  load word
load_last  in  1  qualifies final word of image
load_ready  out  1  controller accepts load word
run_req  in  1  pulse: start/resume execution
halt_req  in  1  pulse: stop fetch
step_req  in  1  pulse: execute exactly one fetch while halted
fetch_inst  in  DATA_W  instruction word currently entering execute (instruction_EX)
imem_we  out  1  instruction RAM write enable
imem_waddr  out  ADDR_W  instruction RAM write address
imem_wdata  out  DATA_W  instruction RAM write data
cpu_rst_n  out  1  active-low synchronous reset to CPU core
pc_en  out  1  fetch enable; PC and instruction_EX hold when 0
halted  out  1  controller in HALT
state  out  3  current FSM state encoding
load_count  out  ADDR_W+1  words written in last/current load
err_overflow  out  1  sticky: image exceeded 2^ADDR_W words

Behaviour:
- States: IDLE=0, LOAD=1, RUN=2, STEP=3, HALT=4. All outputs registered.
- Reset (async, rst=1): state=IDLE, cpu_rst_n=0, pc_en=0, load_ready=0, imem_we=0, imem_waddr=0, imem_wdata=0, halted=0, load_count=0, err_overflow=0. Any state, including mid-load, aborts immediately. RAM contents are not cleared.
- Request priority when simultaneous: load_start > halt_req > step_req > run_req. Requests not valid in the current state are ignored and not queued.
- IDLE: cpu_rst_n=0, pc_en=0. load_start -> LOAD, with load_count=0, address=0 and err_overflow cleared. run_req -> RUN.
- LOAD: cpu_rst_n=0, load_ready=1.
  - Each handshake (valid&ready) at cycle N writes one RAM word: imem_we=1, imem_waddr=address, imem_wdata=load_data at cycle N+1. Then the address and load_count are incremented.
  - A handshake with load_last=1 -> IDLE. load_ready=0 from N+1.
  - The handshake that writes address 2^ADDR_W-1 without load_last sets load_count=2^ADDR_W and moves to the full sub-condition. load_ready stays 1; the next handshake is dropped (no write), sets err_overflow and -> IDLE.
  - load_start while in LOAD restarts at address 0.
- RUN: cpu_rst_n=1, pc_en=1.
  - halt_req at cycle N -> HALT; pc_en=0 at N+1.
  - If fetch_inst==HALT_INST while pc_en=1 at cycle N -> HALT; pc_en=0 at N+1. The instruction following EBREAK may already be fetched but is held, not executed.
  - load_start -> LOAD; cpu_rst_n=0 at N+1.
- HALT: cpu_rst_n=1, pc_en=0, halted=1; architectural state is preserved.
  - run_req -> RUN.
  - step_req -> STEP.
  - load_start -> LOAD.
- STEP: pc_en=1 for exactly one cycle, then -> HALT unconditionally. halt_req during STEP is redundant. load_start in STEP -> LOAD.
- IDLE->RUN: the CPU leaves reset with PC=0 because cpu_rst_n was low for at least one clk.

Decomposition:
- Package cpu_ctrl_pkg: state_e enum (3-bit encodings above), HALT_INST default, IMEM_ADDR_W=12.
- One sub-module, imem_loader: load handshake, address/count counter, overflow detection and the registered RAM write port. It is started and aborted by the top FSM.

Test Plan:
- Reset, load 3 words (0x00500093, 0x00100073, 0xDEADBEEF; last on 3rd) -> imem writes at addr 0,1,2 one cycle after each handshake; load_count=3; state IDLE; cpu_rst_n=0 throughout.
- After load, run_req -> cpu_rst_n=1 and pc_en=1 next cycle. fetch_inst=0x00100073 -> pc_en=0, halted=1 the cycle after.
- In HALT, three step_req pulses -> three single-cycle pc_en pulses, state returns to HALT each time. Then run_req -> pc_en held 1.
- RUN with halt_req and run_req in the same cycle -> HALT (priority). load_start and halt_req together -> LOAD, cpu_rst_n=0.
- Stream 4097 words with no load_last -> 4096 writes (last to addr 0xFFF). 4097th word is not written, err_overflow=1, state IDLE.
- Assert rst mid-load after 5 words -> all outputs reach reset values asynchronously. The next load_start begins again at addr 0 with load_count=0.
